// File: rtl/rv_bus_uart_tx_pkg.sv
// Shared definitions for the bus-mapped UART transmitter: register
// offsets (word index within the 16-byte window), serializer states,
// STATUS bit positions and the effective-divisor helper.
package rv_bus_uart_tx_pkg;

   localparam logic [1:0] REG_DATA   = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;
   localparam logic [1:0] REG_DIV    = 2'd2;

   localparam int STAT_EMPTY = 0;
   localparam int STAT_FULL  = 1;
   localparam int STAT_BUSY  = 2;
   localparam int STAT_COUNT = 4;   // count occupies [11:4]

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_STOP
   } tx_state_e;

   // A stored divisor of 0 would make a zero-length bit; treat it as 1.
   function automatic logic [15:0] eff_div(input logic [15:0] d);
      return (d == 16'd0) ? 16'd1 : d;
   endfunction

endpackage

// File: rtl/rv_sync_fifo.sv
// Synchronous FIFO, parameterised width/depth (depth a power of two).
// Ports: clk/resetn (async active-low), push_i/wdata_i, pop_i,
//        rdata_o (head entry, valid while !empty_o), full_o, empty_o,
//        count_o (occupancy, 0..DEPTH).
// A push while full is accepted only when a pop happens in the same
// cycle; a pop while empty is ignored.
module rv_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [AW:0]      count_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wptr_q, rptr_q;
   logic [AW:0]      count_q;
   logic             do_push, do_pop;

   assign full_o  = (count_q == (AW+1)'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign rdata_o = mem_q[rptr_q];

   assign do_push = push_i && (!full_o || pop_i);
   assign do_pop  = pop_i && !empty_o;

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wptr_q] <= wdata_i;
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (do_push) wptr_q <= wptr_q + AW'(1);
         if (do_pop)  rptr_q <= rptr_q + AW'(1);
         if (do_push && !do_pop)      count_q <= count_q + (AW+1)'(1);
         else if (!do_push && do_pop) count_q <= count_q - (AW+1)'(1);
      end
   end

endmodule

// File: rtl/rv_bus_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the picorv32 native bus.
// Ports: clk, resetn (async active-low); mem_valid/mem_instr/mem_addr/
//        mem_wdata/mem_wstrb request in; mem_ready (one-cycle pulse) and
//        mem_rdata (zero unless ready) out; uart_txd serial out (idle
//        high); tx_empty = FIFO empty and serializer idle.
// Registers (word index): DATA push, STATUS, DIVISOR; index 3 reserved.
module rv_bus_uart_tx
   import rv_bus_uart_tx_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = 32'h1000_1000,
   parameter int          FIFO_DEPTH  = 16,
   parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        mem_valid,
   input  logic        mem_instr,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic [3:0]  mem_wstrb,
   output logic        mem_ready,
   output logic [31:0] mem_rdata,
   output logic        uart_txd,
   output logic        tx_empty
);

   localparam int AW = $clog2(FIFO_DEPTH);

   logic        ready_q;
   logic [31:0] rdata_q;
   logic [15:0] divisor_q;
   tx_state_e   state_q;
   logic [15:0] cnt_q, div_q, div_nx;
   logic [2:0]  bit_q;
   logic [7:0]  shreg_q;
   logic        txd_q, tx_empty_q;

   logic        hit, is_write, data_push, stall, ack;
   logic [1:0]  idx;
   logic [31:0] rd_val;
   logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [7:0]  fifo_rdata;
   logic [AW:0] fifo_count;

   logic unused_bits;
   assign unused_bits = ^{mem_instr, mem_addr[1:0], mem_wdata[31:16]};

   assign hit       = mem_valid && (mem_addr[31:4] == BASE_ADDR[31:4]);
   assign idx       = mem_addr[3:2];
   assign is_write  = |mem_wstrb;
   assign data_push = hit && (idx == REG_DATA) && mem_wstrb[0];
   // A full FIFO only blocks the push if the serializer is not freeing a
   // slot in this very cycle.
   assign stall     = data_push && fifo_full && !fifo_pop;
   // !ready_q enforces the dead cycle after each pulse.
   assign ack       = hit && !ready_q && !stall;
   assign fifo_push = ack && data_push;

   assign fifo_pop = !fifo_empty &&
                     ((state_q == TX_IDLE) || (state_q == TX_STOP && cnt_q == 16'd0));
   assign div_nx   = eff_div(divisor_q);

   always_comb begin
      rd_val = '0;
      case (idx)
         REG_STATUS: begin
            rd_val[STAT_EMPTY]             = fifo_empty;
            rd_val[STAT_FULL]              = fifo_full;
            rd_val[STAT_BUSY]              = (state_q != TX_IDLE);
            rd_val[STAT_COUNT +: 8]        = 8'(fifo_count);
         end
         REG_DIV: rd_val[15:0] = divisor_q;
         default: rd_val = '0;
      endcase
   end

   rv_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .resetn  (resetn),
      .push_i  (fifo_push),
      .wdata_i (mem_wdata[7:0]),
      .pop_i   (fifo_pop),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   // Bus response and DIVISOR register; side effects land on the ack edge.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ready_q   <= 1'b0;
         rdata_q   <= '0;
         divisor_q <= DEFAULT_DIV;
      end else begin
         ready_q <= ack;
         rdata_q <= (ack && !is_write) ? rd_val : 32'd0;
         if (ack && (idx == REG_DIV)) begin
            if (mem_wstrb[0]) divisor_q[7:0]  <= mem_wdata[7:0];
            if (mem_wstrb[1]) divisor_q[15:8] <= mem_wdata[15:8];
         end
      end
   end

   // Serializer: every symbol lasts div_q cycles (counter div_q-1 .. 0).
   // div_q is latched per frame so DIVISOR writes only affect later frames.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= TX_IDLE;
         cnt_q      <= '0;
         div_q      <= 16'd1;
         bit_q      <= '0;
         shreg_q    <= '0;
         txd_q      <= 1'b1;
         tx_empty_q <= 1'b1;
      end else begin
         tx_empty_q <= fifo_empty && (state_q == TX_IDLE);
         case (state_q)
            TX_IDLE: begin
               if (!fifo_empty) begin
                  state_q <= TX_START;
                  shreg_q <= fifo_rdata;
                  div_q   <= div_nx;
                  cnt_q   <= div_nx - 16'd1;
                  txd_q   <= 1'b0;
               end
            end
            TX_START: begin
               if (cnt_q == 16'd0) begin
                  state_q <= TX_DATA;
                  bit_q   <= '0;
                  txd_q   <= shreg_q[0];
                  cnt_q   <= div_q - 16'd1;
               end else begin
                  cnt_q <= cnt_q - 16'd1;
               end
            end
            TX_DATA: begin
               if (cnt_q == 16'd0) begin
                  cnt_q <= div_q - 16'd1;
                  if (bit_q == 3'd7) begin
                     state_q <= TX_STOP;
                     txd_q   <= 1'b1;
                  end else begin
                     bit_q   <= bit_q + 3'd1;
                     shreg_q <= {1'b0, shreg_q[7:1]};
                     txd_q   <= shreg_q[1];
                  end
               end else begin
                  cnt_q <= cnt_q - 16'd1;
               end
            end
            TX_STOP: begin
               if (cnt_q == 16'd0) begin
                  // Back-to-back: next start bit follows the stop bit directly.
                  if (!fifo_empty) begin
                     state_q <= TX_START;
                     shreg_q <= fifo_rdata;
                     div_q   <= div_nx;
                     cnt_q   <= div_nx - 16'd1;
                     txd_q   <= 1'b0;
                  end else begin
                     state_q <= TX_IDLE;
                  end
               end else begin
                  cnt_q <= cnt_q - 16'd1;
               end
            end
            default: state_q <= TX_IDLE;
         endcase
      end
   end

   assign mem_ready = ready_q;
   assign mem_rdata = rdata_q;
   assign uart_txd  = txd_q;
   assign tx_empty  = tx_empty_q;

endmodule

// File: tb/tb_rv_bus_uart_tx.sv
// Scoreboard bench: bus responses and UART frames are queued as
// expectations when stimulus is issued; two monitors pop and compare.
module tb_rv_bus_uart_tx;

   localparam logic [31:0] BASE = 32'h1000_1000;
   localparam logic [31:0] A_DATA = BASE + 32'h0, A_STAT = BASE + 32'h4;
   localparam logic [31:0] A_DIV  = BASE + 32'h8, A_RSV  = BASE + 32'hC;

   logic        clk = 1'b0, resetn = 1'b0;
   logic        mem_valid = 1'b0, mem_instr = 1'b0;
   logic [31:0] mem_addr = '0, mem_wdata = '0;
   logic [3:0]  mem_wstrb = '0;
   logic        mem_ready, uart_txd, tx_empty;
   logic [31:0] mem_rdata;

   always #5 clk = ~clk;

   rv_bus_uart_tx dut (
      .clk(clk), .resetn(resetn), .mem_valid(mem_valid), .mem_instr(mem_instr),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
      .mem_ready(mem_ready), .mem_rdata(mem_rdata), .uart_txd(uart_txd),
      .tx_empty(tx_empty)
   );

   typedef struct { bit chk; logic [31:0] val; } rsp_t;

   int          errors = 0, checks = 0;
   rsp_t        rsp_q[$];
   logic [7:0]  byte_q[$];
   int          model_div = 434;
   bit          hold_mode = 0;
   logic [31:0] hold_exp = '0;
   int          hold_pulses = 0;
   bit          in_frame = 0;
   int          frames_seen = 0, bb_frames = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // ---------------- bus response monitor ----------------
   logic prev_ready = 1'b0;
   rsp_t mon_r;
   always @(negedge clk) begin
      if (mem_ready === 1'b1) begin
         if (hold_mode) begin
            hold_pulses++;
            check("hold_rdata", mem_rdata, hold_exp);
         end else if (rsp_q.size() == 0) begin
            check("unexpected_ready", 32'd1, 32'd0);
         end else begin
            mon_r = rsp_q.pop_front();
            if (mon_r.chk) check("rdata", mem_rdata, mon_r.val);
         end
         check("ready_not_consecutive", {31'd0, prev_ready}, 32'd0);
      end
      prev_ready = mem_ready;
   end

   // ---------------- UART frame monitor ----------------
   // Reference: frame = start(0), 8 data bits LSB first, stop(1), each
   // lasting max(DIVISOR,1) cycles, DIVISOR as of the frame's start.
   initial begin : uart_mon
      int cyc, last_end, d, bad;
      logic [7:0] b;
      logic [9:0] sym;
      bit aborted;
      cyc = 0; last_end = -10;
      forever begin
         @(negedge clk); cyc++;
         if (resetn && uart_txd === 1'b0) begin
            in_frame = 1; frames_seen++;
            if (cyc == last_end + 1) bb_frames++;
            d = (model_div == 0) ? 1 : model_div;
            if (byte_q.size() == 0) begin
               check("unexpected_frame", 32'd1, 32'd0);
               b = 8'h00;
            end else b = byte_q.pop_front();
            sym = {1'b1, b, 1'b0};
            bad = 0; aborted = 0;
            for (int c = 0; c < 10 * d; c++) begin
               if (c > 0) begin @(negedge clk); cyc++; end
               if (!resetn) begin aborted = 1; break; end
               if (uart_txd !== sym[c / d]) bad++;
            end
            if (!aborted) check("frame_bit_errors", bad, 32'd0);
            last_end = cyc;
            in_frame = 0;
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic bus(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] strb,
                      input bit chk, input logic [31:0] exp, input int budget, output int lat);
      rsp_t r;
      r.chk = chk; r.val = exp;
      rsp_q.push_back(r);
      mem_valid = 1'b1; mem_addr = addr; mem_wdata = wdata; mem_wstrb = strb;
      lat = 0;
      do begin @(posedge clk); #1; lat++; end while (mem_ready !== 1'b1 && lat < budget);
      if (mem_ready !== 1'b1) begin
         check("bus_timeout", 32'd0, 32'd1);
         void'(rsp_q.pop_back());
      end
      mem_valid = 1'b0; mem_wstrb = '0;
   endtask

   task automatic wr(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] strb);
      int lat;
      bus(addr, wdata, strb, 1'b0, '0, 2000, lat);
   endtask

   task automatic rd(input logic [31:0] addr, input logic [31:0] exp);
      int lat;
      bus(addr, '0, 4'b0000, 1'b1, exp, 50, lat);
   endtask

   task automatic send(input logic [7:0] b);
      byte_q.push_back(b);
      wr(A_DATA, {24'hABCDEF, b}, 4'b0001);
   endtask

   task automatic set_div(input int d);
      wr(A_DIV, d, 4'b0011);
      model_div = d;
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      do begin @(negedge clk); n++; end
      while (!(byte_q.size() == 0 && !in_frame && tx_empty === 1'b1) && n < budget);
      check("drain_done", {31'd0, n < budget}, 32'd1);
   endtask

   task automatic wait_frame();
      int n;
      n = 0;
      while (!in_frame && n < 200) begin @(negedge clk); n++; end
      check("frame_started", {31'd0, in_frame}, 32'd1);
   endtask

   // ---------------- main sequence ----------------
   initial begin : main
      int lat, f0, bb0, nacks, d, n;
      logic [7:0] b;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", {31'd0, mem_ready}, 32'd0);
      check("rst_rdata", mem_rdata, 32'd0);
      check("rst_txd", {31'd0, uart_txd}, 32'd1);
      check("rst_tx_empty", {31'd0, tx_empty}, 32'd1);
      resetn = 1'b1;
      @(posedge clk); #1;

      // Register map basics
      rd(A_STAT, 32'h0000_0001);
      rd(A_DIV, 32'd434);
      rd(A_DATA, 32'd0);
      wr(A_RSV, 32'hFFFF_FFFF, 4'hF);
      rd(A_RSV, 32'd0);
      wr(A_STAT, 32'hFFFF_FFFF, 4'hF);
      rd(A_STAT, 32'h0000_0001);

      // Address just outside the window: never acknowledged
      mem_valid = 1'b1; mem_addr = BASE + 32'h10; mem_wstrb = 4'b0000;
      nacks = 0;
      repeat (8) begin @(posedge clk); #1; if (mem_ready) nacks++; end
      mem_valid = 1'b0;
      check("nonhit_no_ready", nacks, 32'd0);

      // DIVISOR byte strobes
      wr(A_DIV, 32'h0000_1234, 4'b0011);
      wr(A_DIV, 32'hFFFF_56FF, 4'b0010);
      wr(A_DIV, 32'h0000_9999, 4'b1100);
      rd(A_DIV, 32'h0000_5634);

      // 0x55 at divisor 4
      set_div(4);
      send(8'h55);
      repeat (10) @(negedge clk);
      check("tx_empty_busy", {31'd0, tx_empty}, 32'd0);
      drain(1000);
      check("tx_empty_after", {31'd0, tx_empty}, 32'd1);

      // DATA write without strobe 0 pushes nothing
      f0 = frames_seen;
      wr(A_DATA, 32'h0000_AA00, 4'b0010);
      repeat (30) @(negedge clk);
      check("no_push_wstrb", frames_seen, f0);

      // STATUS while busy with two queued bytes: count=2, busy
      set_div(40);
      for (int i = 0; i < 3; i++) send(8'($urandom));
      rd(A_STAT, 32'h0000_0024);
      drain(5000);

      // Fill the FIFO; the write after it is full must stall, then all frames back-to-back
      set_div(8);
      bb0 = bb_frames;
      for (int i = 0; i < 18; i++) begin
         b = 8'($urandom);
         byte_q.push_back(b);
         bus(A_DATA, {24'd0, b}, 4'b0001, 1'b0, '0, 2000, lat);
      end
      check("full_write_stalled", {31'd0, lat >= 8}, 32'd1);
      rd(A_STAT, 32'h0000_0106);
      drain(5000);
      check("back_to_back", bb_frames - bb0, 32'd17);

      // Held mem_valid on STATUS: separated pulses only
      hold_exp = 32'h0000_0001; hold_pulses = 0; hold_mode = 1;
      mem_valid = 1'b1; mem_addr = A_STAT; mem_wstrb = 4'b0000;
      repeat (5) @(posedge clk);
      #1 mem_valid = 1'b0;
      repeat (2) @(negedge clk);
      hold_mode = 0;
      check("hold_pulses_range", {31'd0, hold_pulses >= 1 && hold_pulses <= 3}, 32'd1);

      // Divisor change mid-frame only affects the next frame
      set_div(4);
      send(8'hC3);
      send(8'h3C);
      wait_frame();
      repeat (15) @(negedge clk);
      set_div(8);
      drain(2000);

      // Randomised divisors (including 0 -> used as 1) and byte bursts
      for (int it = 0; it < 6; it++) begin
         d = $urandom_range(0, 5);
         set_div(d);
         rd(A_DIV, d);
         n = $urandom_range(1, 3);
         for (int k = 0; k < n; k++) send(8'($urandom));
         drain(2000);
      end

      // Reset during data bit 3
      set_div(4);
      send(8'h00);
      wait_frame();
      repeat (17) @(negedge clk);
      check("pre_reset_txd", {31'd0, uart_txd}, 32'd0);
      #2 resetn = 1'b0;
      #1;
      check("async_reset_txd", {31'd0, uart_txd}, 32'd1);
      check("async_reset_tx_empty", {31'd0, tx_empty}, 32'd1);
      repeat (3) @(posedge clk);
      byte_q.delete();
      model_div = 434;
      #1 resetn = 1'b1;
      f0 = frames_seen;
      rd(A_STAT, 32'h0000_0001);
      repeat (60) @(negedge clk);
      check("no_resume_after_reset", frames_seen, f0);

      repeat (2) @(negedge clk);
      check("pending_rsp", rsp_q.size(), 32'd0);
      check("pending_bytes", byte_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
